cc_pixel_packer: RTL and testbench

- Sits directly downstream of the CMOS capture host on the camera clock.
- Gated by the host's `cc_enabled` window, it packs accepted 16-bit pixels into 32-bit words and tags each word with start-of-frame and end-of-frame bits.
- Words are buffered in a small synchronous FIFO and presented to the storage writer over a valid/ready stream.
- Reports words per frame and overflow status.

---
 rtl/cc_pkg.sv | 30 +++
 rtl/cc_sync_fifo.sv | 61 ++++++
 rtl/cc_pixel_packer.sv | 204 ++++++++++++++++++++
 tb/tb_cc_pixel_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared widths, FSM states and FIFO entry layout for the pixel packer
package cc_pkg;

  localparam int CC_PIX_W   = 16;
  localparam int CC_WORD_W  = 32;
  localparam int CC_ENTRY_W = CC_WORD_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } cc_state_e;

  // Bit 33 = eof, bit 32 = sof, bits [31:0] = data.
  typedef struct packed {
    logic                 eof;
    logic                 sof;
    logic [CC_WORD_W-1:0] data;
  } cc_entry_t;

  function automatic cc_entry_t cc_make_entry(input logic [CC_WORD_W-1:0] data,
                                              input logic sof, input logic eof);
    cc_entry_t e;
    e.eof  = eof;
    e.sof  = sof;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/cc_sync_fifo.sv
// rtl/cc_sync_fifo.sv - single-clock first-word-fall-through FIFO with registered storage
module cc_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a word when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/cc_pixel_packer.sv
// rtl/cc_pixel_packer.sv - packs 16-bit camera pixels into sof/eof-tagged 32-bit words
// Optional test-pattern source enabled by CC_PIXEL_PACKER_TESTPAT_EN.
module cc_pixel_packer
  import cc_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 16,
  parameter logic [CC_PIX_W-1:0] PAD_VALUE  = 16'h0000
) (
  input  logic                 cmos_clk_i,
  input  logic                 rst,
  input  logic [CC_PIX_W-1:0]  cmos_data_i,
  input  logic                 cmos_valid_i,
  input  logic                 cc_enabled,
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
  input  logic                 test_en_i,
`endif
  output logic [CC_WORD_W-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          words_per_frame,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cc_state_e           state_q, state_d;
  logic                en_q, en_d;
  logic                arm_q, arm_d;
  logic                phase_q, phase_d;
  logic [CC_PIX_W-1:0] half_q, half_d;
  logic                stg_valid_q, stg_valid_d;
  cc_entry_t           stg_q, stg_d;
  logic                first_q, first_d;
  logic [31:0]         word_cnt_q, word_cnt_d;
  logic [31:0]         wpf_q, wpf_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_q, drop_d;

  logic                rise, fall, accept;
  logic                push, drop, pop;
  cc_entry_t           push_entry;
  logic [CC_PIX_W-1:0] pix;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic [CC_ENTRY_W-1:0] fifo_dout;
  cc_entry_t           head;

`ifdef CC_PIXEL_PACKER_TESTPAT_EN
  logic [CC_PIX_W-1:0] pat_q, pat_d;
  assign pix = test_en_i ? pat_q : cmos_data_i;
`else
  assign pix = cmos_data_i;
`endif

  // arm_q blocks a frame that was already running when reset released.
  assign rise      = cc_enabled && !en_q && arm_q;
  assign fall      = !cc_enabled && en_q;
  assign accept    = (state_q == ST_ACTIVE) && cc_enabled && cmos_valid_i;
  assign pop       = out_valid && out_ready;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign drop      = push && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    en_d        = cc_enabled;
    arm_d       = arm_q || !cc_enabled;
    phase_d     = phase_q;
    half_d      = half_q;
    stg_valid_d = stg_valid_q;
    stg_d       = stg_q;
    first_d     = first_q;
    word_cnt_d  = word_cnt_q;
    wpf_d       = wpf_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    push        = 1'b0;
    push_entry  = stg_q;
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
    pat_d       = pat_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_ACTIVE;
          phase_d    = 1'b0;
          word_cnt_d = '0;
          first_d    = 1'b1;
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
          pat_d      = '0;
`endif
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
          pat_d = pat_q + 16'd1;
`endif
          if (!phase_q) begin
            half_d  = pix;
            phase_d = 1'b1;
          end else begin
            push        = stg_valid_q;
            stg_d       = cc_make_entry({pix, half_q}, first_q, 1'b0);
            stg_valid_d = 1'b1;
            first_d     = 1'b0;
            phase_d     = 1'b0;
          end
        end else if (fall) begin
          state_d = ST_FLUSH;
          if (phase_q) begin
            push        = stg_valid_q;
            stg_d       = cc_make_entry({PAD_VALUE, half_q}, first_q, 1'b0);
            stg_valid_d = 1'b1;
            first_d     = 1'b0;
            phase_d     = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        if (stg_valid_q) begin
          push        = 1'b1;
          push_entry  = cc_make_entry(stg_q.data, stg_q.sof, 1'b1);
          stg_valid_d = 1'b0;
          wpf_d       = word_cnt_q + 32'd1;
        end else begin
          wpf_d = word_cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) word_cnt_d = word_cnt_q + 32'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge cmos_clk_i) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      arm_q       <= 1'b0;
      phase_q     <= 1'b0;
      half_q      <= '0;
      stg_valid_q <= 1'b0;
      stg_q       <= '0;
      first_q     <= 1'b0;
      word_cnt_q  <= '0;
      wpf_q       <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
      pat_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      arm_q       <= arm_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      stg_valid_q <= stg_valid_d;
      stg_q       <= stg_d;
      first_q     <= first_d;
      word_cnt_q  <= word_cnt_d;
      wpf_q       <= wpf_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
      pat_q       <= pat_d;
`endif
    end
  end

  cc_sync_fifo #(
    .WIDTH (CC_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (cmos_clk_i),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (fifo_dout),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head            = fifo_dout;
  assign out_valid       = !fifo_empty;
  assign out_data        = head.data;
  assign out_sof         = head.sof;
  assign out_eof         = head.eof;
  assign words_per_frame = wpf_q;
  assign overflow        = overflow_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_cc_pixel_packer.sv
// tb/tb_cc_pixel_packer.sv - scoreboard bench for cc_pixel_packer with a 4-deep FIFO
module tb_cc_pixel_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmos_data;
  logic        cmos_valid;
  logic        cc_enabled;
  logic        test_en;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] words_per_frame;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  logic [15:0] px[$];

  always #5 clk = ~clk;

  cc_pixel_packer #(
    .FIFO_DEPTH (4),
    .PAD_VALUE  (16'h0000)
  ) dut (
    .cmos_clk_i      (clk),
    .rst             (rst),
    .cmos_data_i     (cmos_data),
    .cmos_valid_i    (cmos_valid),
    .cc_enabled      (cc_enabled),
`ifdef CC_PIXEL_PACKER_TESTPAT_EN
    .test_en_i       (test_en),
`endif
    .out_data        (out_data),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .words_per_frame (words_per_frame),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", {out_eof, out_sof, out_data});
      end else begin
        check("out_word", {out_eof, out_sof, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] data, input logic sof, input logic eof);
    exp_q.push_back({eof, sof, data});
  endtask

  task automatic run_frame();
    cc_enabled = 1'b1;
    tick();
    foreach (px[i]) begin
      cmos_valid = 1'b1;
      cmos_data  = px[i];
      tick();
    end
    cmos_valid = 1'b0;
    cc_enabled = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check(name, 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    rst        = 1'b1;
    cmos_data  = '0;
    cmos_valid = 1'b0;
    cc_enabled = 1'b0;
    test_en    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_out_valid", 34'(out_valid), 34'd0);
    check("reset_out_data", 34'(out_data), 34'd0);
    check("reset_wpf", 34'(words_per_frame), 34'd0);
    check("reset_overflow", 34'(overflow), 34'd0);
    check("reset_drop_count", 34'(drop_count), 34'd0);

    // Six pixels -> three words.
    px = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    expect_word(32'h00020001, 1'b1, 1'b0);
    expect_word(32'h00040003, 1'b0, 1'b0);
    expect_word(32'h00060005, 1'b0, 1'b1);
    run_frame();
    wait_drain("drain_frame6");
    check("wpf_frame6", 34'(words_per_frame), 34'd3);

    // Odd length frame gets padded.
    px = '{16'h000A, 16'h000B, 16'h000C};
    expect_word(32'h000B000A, 1'b1, 1'b0);
    expect_word(32'h0000000C, 1'b0, 1'b1);
    run_frame();
    wait_drain("drain_frame3");
    check("wpf_frame3", 34'(words_per_frame), 34'd2);

    // Single-pixel frame: one word carrying both sof and eof.
    px = '{16'h1234};
    expect_word(32'h00001234, 1'b1, 1'b1);
    run_frame();
    wait_drain("drain_frame1");
    check("wpf_frame1", 34'(words_per_frame), 34'd1);

    // Enable pulse without pixels.
    px = {};
    run_frame();
    check("wpf_empty", 34'(words_per_frame), 34'd0);
    check("empty_out_valid", 34'(out_valid), 34'd0);

    // Backpressure: 6 words into a 4-deep FIFO, last two dropped.
    out_ready = 1'b0;
    px = {};
    for (int i = 1; i <= 12; i++) px.push_back(16'(i));
    run_frame();
    check("ovf_overflow", 34'(overflow), 34'd1);
    check("ovf_drop_count", 34'(drop_count), 34'd2);
    check("ovf_wpf", 34'(words_per_frame), 34'd6);
    check("ovf_out_valid", 34'(out_valid), 34'd1);
    check("ovf_stable_head", {out_eof, out_sof, out_data}, {1'b0, 1'b1, 32'h00020001});
    expect_word(32'h00020001, 1'b1, 1'b0);
    expect_word(32'h00040003, 1'b0, 1'b0);
    expect_word(32'h00060005, 1'b0, 1'b0);
    expect_word(32'h00080007, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_drain("drain_overflow");
    check("ovf_drained_valid", 34'(out_valid), 34'd0);

    // Reset in the middle of a frame; the rest of that frame is ignored.
    cc_enabled = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      cmos_valid = 1'b1;
      cmos_data  = 16'h0100 + 16'(i);
      tick();
    end
    cmos_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_overflow", 34'(overflow), 34'd0);
    check("rst_drop_count", 34'(drop_count), 34'd0);
    check("rst_wpf", 34'(words_per_frame), 34'd0);
    for (int i = 0; i < 4; i++) begin
      cmos_valid = 1'b1;
      cmos_data  = 16'h0200 + 16'(i);
      tick();
    end
    cmos_valid = 1'b0;
    cc_enabled = 1'b0;
    repeat (4) tick();
    check("rst_ignored_valid", 34'(out_valid), 34'd0);
    check("rst_ignored_wpf", 34'(words_per_frame), 34'd0);

    // Next full frame; with the test pattern enabled the counter yields the same values.
    test_en = 1'b1;
    px = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    expect_word(32'h00010000, 1'b1, 1'b0);
    expect_word(32'h00030002, 1'b0, 1'b1);
    run_frame();
    wait_drain("drain_after_reset");
    check("wpf_after_reset", 34'(words_per_frame), 34'd2);
    test_en = 1'b0;

    repeat (3) tick();
    check("scoreboard_empty", 34'(exp_q.size()), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
